// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side initiator for the combinational 32-bit ALU.
// Takes funct-coded commands, drives the ALU from registers, captures its
// result and returns it over a result handshake.
// Optional feature macro: ALU_OP_SEQUENCER_MUL_EN. When it is defined, MULTU
// (funct 011001) is built as a shift-add multiply that reuses the ALU adder
// once per cycle. When it is undefined, MULTU decodes as illegal.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised, it and its payload hold until that
// edge. Ready may depend on state but never on the same channel's valid.
// in_ready is high only in IDLE, so commands never overlap.
// The result channel holds out_valid, result, zero and illegal stable until
// out_ready is seen.
module alu_op_sequencer #(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;

  // The multiplier walks one bit per WIDTH cycle, so the two must agree.
  if (MUL_STEPS != WIDTH) begin : g_cfg_check
    $error("alu_op_sequencer: MUL_STEPS must equal WIDTH");
  end

  logic [2:0] dec_f;
  logic       dec_legal;

`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  logic             dec_mul;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;

  // alu_a/alu_b track acc/mcand during MUL, so alu_y is acc + mcand.
  assign acc_nxt = mplier[0] ? alu_y : acc;
`endif

  assign in_ready  = (state == S_IDLE);
  assign state_dbg = state;

  // Decode funct into the ALU control word. F[2] inverts B and sets the carry-in.
  always_comb begin
    dec_f     = 3'b000;
    dec_legal = 1'b1;
`ifdef ALU_OP_SEQUENCER_MUL_EN
    dec_mul   = 1'b0;
`endif
    case (funct)
      6'b100000: dec_f = 3'b010; // ADD
      6'b100010: dec_f = 3'b110; // SUB
      6'b100100: dec_f = 3'b000; // AND
      6'b100101: dec_f = 3'b001; // OR
      6'b101010: dec_f = 3'b111; // SLT
`ifdef ALU_OP_SEQUENCER_MUL_EN
      6'b011001: begin           // MULTU: the adder is reused each step
        dec_f   = 3'b010;
        dec_mul = 1'b1;
      end
`endif
      default:   dec_legal = 1'b0;
    endcase
  end

  // Control FSM. This block also holds the ALU operand registers and the result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_f     <= 3'b000;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_OP_SEQUENCER_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            alu_a <= op_a;
            alu_b <= op_b;
            alu_f <= dec_f;
            if (!dec_legal) begin
              // The result is known at accept, so the operation goes straight to DONE.
              result  <= '0;
              zero    <= 1'b1;
              illegal <= 1'b1;
              state   <= S_DONE;
            end
`ifdef ALU_OP_SEQUENCER_MUL_EN
            else if (dec_mul) begin
              alu_a  <= '0;
              alu_b  <= op_a;
              mcand  <= op_a;
              mplier <= op_b;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_MUL;
            end
`endif
            else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          result  <= alu_y;
          zero    <= (alu_y == '0);
          illegal <= 1'b0;
          state   <= S_DONE;
        end
`ifdef ALU_OP_SEQUENCER_MUL_EN
        S_MUL: begin
          // One shift-add step per cycle. A zero multiplier still uses the full count.
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          alu_a  <= acc_nxt;
          alu_b  <= mcand << 1;
          if (cnt == CNT_LAST) begin
            result  <= acc_nxt;
            zero    <= (acc_nxt == '0);
            illegal <= 1'b0;
            state   <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          // out_valid rises one edge after entry, then waits for the consumer.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. It contains a behavioural ALU, directed vectors,
// multi-cycle corner sequences, and random commands checked against a
// reference model. Build with +define+ALU_OP_SEQUENCER_MUL_EN to cover MULTU.
module tb_alu_op_sequencer;
  localparam int W = 32;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef ALU_OP_SEQUENCER_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   funct = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_f;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, illegal;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  logic [W+1:0] exp_q[$]; // {illegal, zero, result}

  alu_op_sequencer #(.WIDTH(W), .MUL_STEPS(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_y(alu_y), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Behavioural combinational ALU following the F contract.
  logic [W-1:0] alu_bb, alu_s;
  always_comb begin
    alu_bb = alu_f[2] ? ~alu_b : alu_b;
    alu_s  = alu_a + alu_bb + {{(W-1){1'b0}}, alu_f[2]};
    case (alu_f[1:0])
      2'b00:   alu_y = alu_a & alu_bb;
      2'b01:   alu_y = alu_a | alu_bb;
      2'b10:   alu_y = alu_s;
      default: alu_y = {{(W-1){1'b0}}, alu_s[W-1]};
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model. Returns {illegal, result}.
  function automatic logic [W:0] ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0]   d;
    case (f)
      F_ADD: return {1'b0, a + b};
      F_SUB: return {1'b0, a - b};
      F_AND: return {1'b0, a & b};
      F_OR:  return {1'b0, a | b};
      F_SLT: begin
        d = a - b;
        return {1'b0, {(W-1){1'b0}}, d[W-1]};
      end
      F_MULTU: begin
        if (MUL_EN) begin
          p = (2*W)'(a) * (2*W)'(b);
          return {1'b0, p[W-1:0]};
        end
        return {1'b1, {W{1'b0}}};
      end
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  function automatic int ref_lat(input logic ill, input logic [5:0] f);
    if (ill) return 1;
    if (f == F_MULTU) return W + 1;
    return 2;
  endfunction

  function automatic logic [2:0] ref_f(input logic [5:0] f);
    case (f)
      F_SUB:   return 3'b110;
      F_AND:   return 3'b000;
      F_OR:    return 3'b001;
      F_SLT:   return 3'b111;
      default: return 3'b010; // ADD and MULTU
    endcase
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, " alu_a"}, alu_a, '0);
    check({name, " alu_b"}, alu_b, '0);
    check({name, " result"}, result, '0);
    check({name, " alu_f"}, W'(alu_f), '0);
    check({name, " flags"}, W'({out_valid, illegal, zero}), W'(3'b001));
  endtask

  // Driver: issue one command, measure its latency, check it, apply backpressure, then release it.
  task automatic do_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold,
                       input logic exp_ill, input logic [W-1:0] exp_res);
    logic [W+1:0] e;
    int lat;
    int bad;
    exp_q.push_back({exp_ill, (exp_res == '0), exp_res});
    @(negedge clk);
    check({name, " in_ready idle"}, W'(in_ready), W'(1));
    in_valid = 1'b1; funct = f; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (!exp_ill) check({name, " alu_f"}, W'(alu_f), W'(ref_f(f)));
    if (!exp_ill && f != F_MULTU) check({name, " alu_a"}, alu_a, a);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({name, " latency"}, W'(lat), W'(ref_lat(exp_ill, f)));
    e = exp_q.pop_front();
    check({name, " result"}, result, e[W-1:0]);
    check({name, " zero"}, W'(zero), W'(e[W]));
    check({name, " illegal"}, W'(illegal), W'(e[W+1]));
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; funct = F_ADD; op_a = $urandom; op_b = $urandom;
      @(posedge clk); @(negedge clk);
      if (!out_valid || in_ready || result !== e[W-1:0] || zero !== e[W] || illegal !== e[W+1]) bad++;
    end
    in_valid = 1'b0;
    if (hold > 0) check({name, " hold stable"}, W'(bad), '0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({name, " released"}, W'({out_valid, in_ready}), W'(2'b01));
  endtask

  typedef struct {
    string        name;
    logic [5:0]   f;
    logic [W-1:0] a, b, res;
    logic         ill;
    int           hold;
  } vec_t;

  vec_t         vecs[$];
  logic [W:0]   m;
  logic [5:0]   rf;
  logic [W-1:0] ra, rb;
  int           ghost;
  int           k;

  initial begin
    // Directed vectors with hand-computed expectations.
    vecs.push_back('{"add",      F_ADD, 32'h5,        32'h3,        32'h8,        1'b0, 0});
    vecs.push_back('{"sub_zero", F_SUB, 32'h5,        32'h5,        32'h0,        1'b0, 0});
    vecs.push_back('{"slt_neg",  F_SLT, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 0});
    vecs.push_back('{"slt_swap", F_SLT, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b0, 0});
    vecs.push_back('{"and_bp",   F_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 10});
    vecs.push_back('{"or",       F_OR,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 0});
    vecs.push_back('{"illegal",  6'b111111, 32'h12,   32'h34,       32'h0,        1'b1, 2});
`ifdef ALU_OP_SEQUENCER_MUL_EN
    vecs.push_back('{"mul_1234", F_MULTU, 32'h00001234, 32'h10,       32'h00012340, 1'b0, 0});
    vecs.push_back('{"mul_ones", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 0});
    vecs.push_back('{"mul_zero", F_MULTU, 32'h7,        32'h0,        32'h0,        1'b0, 1});
`else
    vecs.push_back('{"multu_off", F_MULTU, 32'h7,       32'h3,        32'h0,        1'b1, 0});
`endif

    // Power-on reset.
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("por");
    check("por in_ready", W'(in_ready), W'(1));
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].ill, vecs[i].res);

    // No stray result may follow the rejected second command.
    ghost = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) ghost++;
    end
    check("no ghost after backpressure", W'(ghost), '0);

    // Reset in the middle of an operation.
    @(negedge clk);
`ifdef ALU_OP_SEQUENCER_MUL_EN
    in_valid = 1'b1; funct = F_MULTU; op_a = 32'h12345678; op_b = 32'h9ABCDEF1;
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    repeat (9) @(posedge clk);
`else
    in_valid = 1'b1; funct = F_ADD; op_a = 32'h11; op_b = 32'h22;
    @(posedge clk);
    in_valid = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midop reset");
    @(negedge clk) reset_n = 1'b1;
    check("post reset in_ready", W'(in_ready), W'(1));
    ghost = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) ghost++;
    end
    check("no stale result", W'(ghost), '0);
    do_op("add_after_reset", F_ADD, 32'h2, 32'h2, 0, 1'b0, 32'h4);

    // Random commands checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 6);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      case (k)
        0: rf = F_ADD;
        1: rf = F_SUB;
        2: rf = F_AND;
        3: rf = F_OR;
        4: rf = F_SLT;
        5: rf = F_MULTU;
        default: begin
          do rf = 6'($urandom_range(0, 63));
          while (rf inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULTU});
        end
      endcase
      m = ref_op(rf, ra, rb);
      do_op("rand", rf, ra, rb, $urandom_range(0, 3), m[W], m[W-1:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side initiator for the team's combinational 32-bit ALU.
- Accepts funct-coded operations over a valid/ready handshake and decodes funct into the ALU's 3-bit control F.
- Drives the ALU operand and control ports from registers, captures the ALU result, and returns it over a second valid/ready handshake.
- Also sequences a multi-cycle unsigned multiply by reusing the ALU adder once per cycle. It sits between the decode stage and the ALU in the processor datapath.

Parameters:
- WIDTH, 32, datapath width; must match the ALU width.
- MUL_STEPS, 32, number of shift-add iterations for MULTU; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready at a clk edge.
- funct  input  6  operation code.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- alu_a  output  WIDTH  ALU A operand, registered.
- alu_b  output  WIDTH  ALU B operand, registered.
- alu_f  output  3  ALU control F, registered.
- alu_y  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_f.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid & out_ready at a clk edge.
- result  output  WIDTH  captured result.
- zero  output  1  result == 0.
- illegal  output  1  funct not recognised; qualified by out_valid.

Behaviour:
- Reset: asynchronous on reset_n low.
  - state=IDLE; alu_a, alu_b, result=0; alu_f=3'b000; out_valid, illegal=0; zero=1.
  - Handshakes are ignored while reset_n is low.
  - Reset during EXEC or MUL abandons the operation; no result is emitted.
- F encoding (ALU contract):
  - F[2] inverts B and drives carry-in.
  - F[1:0] selects 00 AND, 01 OR, 10 ADD, 11 SLT (sign bit of A-B, zero-extended).
- funct decode:
  - 100000 ADD -> 010
  - 100010 SUB -> 110
  - 100100 AND -> 000
  - 100101 OR -> 001
  - 101010 SLT -> 111
  - 011001 MULTU -> multi-cycle
  - anything else -> illegal.
- States: IDLE, EXEC, MUL, DONE. in_ready=1 only in IDLE; there is no overlap between commands.
- IDLE:
  - On accept, op_a -> alu_a, op_b -> alu_b, decoded F -> alu_f.
  - Next state: EXEC for a legal single-cycle op; MUL for MULTU; DONE for an illegal funct.
  - Illegal funct: result=0, illegal=1, zero=1.
- EXEC: one cycle. At its closing edge, alu_y -> result, zero=(alu_y==0), illegal=0; go DONE.
  - Latency for single-cycle ops: out_valid rises 2 edges after the accept edge.
- MUL:
  - Internal registers: mcand=op_a, mplier=op_b, acc=0, cnt=0, all loaded at accept.
  - While in MUL, alu_a=acc, alu_b=mcand, alu_f=010.
  - Each edge: if mplier[0] then acc<=alu_y; mcand<=mcand<<1; mplier<=mplier>>1; cnt++.
  - After MUL_STEPS cycles, the final acc (low WIDTH bits of the product; overflow discarded) -> result, zero updated, go DONE.
  - Latency: out_valid rises MUL_STEPS+1 edges after the accept edge.
  - No early termination; a zero multiplier still takes the full count.
- DONE:
  - out_valid=1; result, zero and illegal are held stable.
  - On out_ready, go IDLE and out_valid=0 at that edge.
  - Backpressure may last indefinitely.
- alu_a, alu_b and alu_f hold their last values in DONE and IDLE.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_MUL_EN.
- Defined: MULTU (011001) is supported as above and the MUL state, mcand/mplier/acc and the step counter are built.
- Undefined: none of that logic exists, and 011001 decodes as illegal (result=0, illegal=1, out_valid 1 edge after accept).

Test Plan:
- ADD: op_a=0x00000005, op_b=0x00000003, funct=100000 -> alu_f=010; result=0x00000008, zero=0, illegal=0, out_valid 2 edges after accept.
- SUB/SLT: 5-5 with funct=100010 -> result=0, zero=1. SLT with op_a=0xFFFFFFFF (-1), op_b=1 -> result=0x00000001. Same SLT with operands swapped -> 0x00000000.
- Backpressure and illegal funct:
  - Hold out_ready=0 for 10 cycles after an AND of 0xF0F0F0F0 & 0xFF00FF00 -> result=0xF000F000 stays stable, in_ready=0 throughout, a second in_valid is not accepted.
  - funct=111111 -> illegal=1, result=0.
- MULTU (macro defined):
  - 0x00001234 x 0x00000010 -> result=0x00012340, out_valid exactly 33 edges after accept.
  - 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001.
  - 7 x 0 -> result=0, zero=1.
- Reset mid-operation: drop reset_n at MUL step 10 -> all outputs at reset values immediately. After release, in_ready=1, and a new ADD 2+2 returns 4 with no stale result emitted.
- Macro undefined: funct=011001 -> illegal=1, out_valid 1 edge after accept.
